// File: rtl/aes_trace_pkg.sv
// Shared types and helpers for the AES trace sequencer.
package aes_trace_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_RUN   = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } trace_state_e;

    localparam int DEF_DATA_W  = 128;
    localparam int DEF_NUM_VEC = 4;

    // Ceiling log2, never below 1 so a single-entry list still has an index bit
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/aes_vec_ram.sv
// Plaintext vector store: synchronous write, asynchronous read, no reset.
module aes_vec_ram
    import aes_trace_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_VEC = DEF_NUM_VEC,
    parameter int IDX_W   = clog2_min1(NUM_VEC)
) (
    input  logic              clk_i,
    input  logic              wr_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Array spans the full index range so any index value is a legal select;
    // entries at or above NUM_VEC are never written and never read.
    localparam int DEPTH = 1 << IDX_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port; addresses past the last stored vector are discarded
    always_ff @(posedge clk_i) begin
        if (wr_i && (int'(waddr_i) < NUM_VEC)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/aes_trace_driver.sv
// Stimulus sequencer: replays stored plaintexts into an AES core under one
// latched key, triggers at each encryption start and returns tagged results.
module aes_trace_driver
    import aes_trace_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_VEC     = DEF_NUM_VEC,
    parameter int IDX_W       = clog2_min1(NUM_VEC),
    parameter int GAP_CYC     = 16,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic              AES_clk,
    input  logic              AES_rst,
    input  logic              AES_start,
    input  logic              AES_loop,
    input  logic              AES_stop,
    input  logic [DATA_W-1:0] AES_key_in,
    input  logic              AES_vec_wr,
    input  logic [IDX_W-1:0]  AES_vec_addr,
    input  logic [DATA_W-1:0] AES_vec_data,
    output logic              AES_core_en,
    output logic [DATA_W-1:0] AES_core_data,
    output logic [DATA_W-1:0] AES_core_key,
    input  logic              AES_core_valid,
    input  logic [DATA_W-1:0] AES_core_result,
    output logic              AES_trig,
    output logic              AES_res_valid,
    output logic [DATA_W-1:0] AES_res_data,
    output logic [IDX_W-1:0]  AES_res_idx,
    output logic              AES_busy,
    output logic              AES_done,
    output logic              AES_timeout
);

    // A zero gap still spends one cycle in GAP so en visibly drops
    localparam int               GAP_LEN  = (GAP_CYC < 1) ? 1 : GAP_CYC;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_LEN);
    localparam logic [CNT_W-1:0] TO_END   = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    trace_state_e      state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stop_q, stop_d;
    logic              loop_q, loop_d;
    logic              timeout_q, timeout_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [DATA_W-1:0] core_data_q, core_data_d;
    logic [DATA_W-1:0] core_key_q, core_key_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [IDX_W-1:0]  res_idx_q, res_idx_d;
    logic              busy;
    logic [DATA_W-1:0] vec_rd;

    assign busy = (state_q != ST_IDLE);

    // Vector memory is only writable while the sequencer is idle
    aes_vec_ram #(
        .DATA_W  (DATA_W),
        .NUM_VEC (NUM_VEC),
        .IDX_W   (IDX_W)
    ) u_vec_ram (
        .clk_i   (AES_clk),
        .wr_i    (AES_vec_wr && !busy),
        .waddr_i (AES_vec_addr),
        .wdata_i (AES_vec_data),
        .raddr_i (idx_q),
        .rdata_o (vec_rd)
    );

    // Next-state logic: sequencing, cycle counter, latches and result capture
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        stop_d      = stop_q;
        loop_d      = loop_q;
        timeout_d   = timeout_q;
        key_d       = key_q;
        core_data_d = core_data_q;
        core_key_d  = core_key_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;

        // Stop is remembered while running and acted on only at the end of GAP
        if (busy && AES_stop) begin
            stop_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (AES_start) begin
                    key_d     = AES_key_in;
                    loop_d    = AES_loop;
                    timeout_d = 1'b0;
                    stop_d    = 1'b0;
                    idx_d     = '0;
                    cnt_d     = '0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                core_data_d = vec_rd;
                core_key_d  = key_q;
                cnt_d       = CNT_ONE;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                // A valid on the expiry cycle takes priority over the timeout
                if (AES_core_valid) begin
                    res_valid_d = 1'b1;
                    res_data_d  = AES_core_result;
                    res_idx_d   = idx_q;
                    cnt_d       = CNT_ONE;
                    state_d     = ST_GAP;
                end else if (cnt_q >= TO_END) begin
                    timeout_d = 1'b1;
                    cnt_d     = CNT_ONE;
                    state_d   = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q >= GAP_END) begin
                    cnt_d = '0;
                    if (stop_q) begin
                        state_d = ST_DONE;
                    end else if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_SETUP;
                    end else if (loop_q) begin
                        idx_d   = '0;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears every visible output
    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            stop_q      <= 1'b0;
            loop_q      <= 1'b0;
            timeout_q   <= 1'b0;
            key_q       <= '0;
            core_data_q <= '0;
            core_key_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            stop_q      <= stop_d;
            loop_q      <= loop_d;
            timeout_q   <= timeout_d;
            key_q       <= key_d;
            core_data_q <= core_data_d;
            core_key_q  <= core_key_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
        end
    end

    // en follows RUN directly; trig marks the first RUN cycle (counter at 1)
    assign AES_core_en   = (state_q == ST_RUN);
    assign AES_trig      = (state_q == ST_RUN) && (cnt_q == CNT_ONE);
    assign AES_core_data = core_data_q;
    assign AES_core_key  = core_key_q;
    assign AES_res_valid = res_valid_q;
    assign AES_res_data  = res_data_q;
    assign AES_res_idx   = res_idx_q;
    assign AES_busy      = busy;
    assign AES_done      = (state_q == ST_DONE);
    assign AES_timeout   = timeout_q;

endmodule

// File: tb/tb_aes_trace_driver.sv
// Directed bench for aes_trace_driver: one single-vector and one four-vector
// instance, each driven by a simple core model (result = data ^ key).
module tb_aes_trace_driver;

    localparam int CORE_LAT = 10;
    localparam int GAP      = 16;
    localparam int TO_CYC   = 64;

    localparam logic [127:0] K    = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
    localparam logic [127:0] V1_0 = 128'h00000046_00000000_00000000_00000000;
    localparam logic [127:0] V1_1 = 128'h00000047_00000000_00000000_00000000;
    localparam logic [127:0] BAD  = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

    typedef struct {
        logic [127:0] vec;
        int           idx;
        logic [127:0] exp;
    } vec_rec_t;

    logic clk;

    // single-vector instance signals
    logic         a_rst, a_start, a_loop, a_stop, a_wr;
    logic [127:0] a_key, a_wdata;
    logic [0:0]   a_addr;
    logic         a_en, a_cvalid, a_trig, a_rv, a_busy, a_done, a_to;
    logic [127:0] a_cdata, a_ckey, a_cres, a_rd;
    logic [0:0]   a_ri;

    // four-vector instance signals
    logic         b_rst, b_start, b_loop, b_stop, b_wr;
    logic [127:0] b_key, b_wdata;
    logic [1:0]   b_addr;
    logic         b_en, b_cvalid, b_trig, b_rv, b_busy, b_done, b_to;
    logic [127:0] b_cdata, b_ckey, b_cres, b_rd;
    logic [1:0]   b_ri;
    bit           b_dead;

    int n_chk, n_pass;

    logic [127:0] q_data[$];
    logic [127:0] q_pres[$];
    int           q_idx[$];
    int           q_gap[$];
    int           q_hi[$];
    int           n_trig, n_done;

    aes_trace_driver #(
        .DATA_W(128), .NUM_VEC(1), .GAP_CYC(GAP), .TIMEOUT_CYC(TO_CYC), .CNT_W(16)
    ) u1 (
        .AES_clk(clk), .AES_rst(a_rst), .AES_start(a_start), .AES_loop(a_loop),
        .AES_stop(a_stop), .AES_key_in(a_key), .AES_vec_wr(a_wr),
        .AES_vec_addr(a_addr), .AES_vec_data(a_wdata), .AES_core_en(a_en),
        .AES_core_data(a_cdata), .AES_core_key(a_ckey), .AES_core_valid(a_cvalid),
        .AES_core_result(a_cres), .AES_trig(a_trig), .AES_res_valid(a_rv),
        .AES_res_data(a_rd), .AES_res_idx(a_ri), .AES_busy(a_busy),
        .AES_done(a_done), .AES_timeout(a_to)
    );

    aes_trace_driver #(
        .DATA_W(128), .NUM_VEC(4), .GAP_CYC(GAP), .TIMEOUT_CYC(TO_CYC), .CNT_W(16)
    ) u4 (
        .AES_clk(clk), .AES_rst(b_rst), .AES_start(b_start), .AES_loop(b_loop),
        .AES_stop(b_stop), .AES_key_in(b_key), .AES_vec_wr(b_wr),
        .AES_vec_addr(b_addr), .AES_vec_data(b_wdata), .AES_core_en(b_en),
        .AES_core_data(b_cdata), .AES_core_key(b_ckey), .AES_core_valid(b_cvalid),
        .AES_core_result(b_cres), .AES_trig(b_trig), .AES_res_valid(b_rv),
        .AES_res_data(b_rd), .AES_res_idx(b_ri), .AES_busy(b_busy),
        .AES_done(b_done), .AES_timeout(b_to)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // core models: valid for one cycle on the CORE_LAT-th consecutive en cycle
    initial begin
        int rc;
        rc = 0;
        a_cvalid = 1'b0;
        a_cres   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (a_en) rc++; else rc = 0;
            a_cvalid = a_en && (rc == CORE_LAT);
            a_cres   = a_cvalid ? (a_cdata ^ a_ckey) : '0;
        end
    end

    initial begin
        int rc;
        rc = 0;
        b_cvalid = 1'b0;
        b_cres   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (b_en) rc++; else rc = 0;
            b_cvalid = !b_dead && b_en && (rc == CORE_LAT);
            b_cres   = b_cvalid ? (b_cdata ^ b_ckey) : '0;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Start the four-vector instance and watch it until done, recording events.
    task automatic run4(input bit lp, input int stop_trig, input int wr_trig,
                        input bit gap_start, input int max_cyc);
        bit seen_hi, prev_en, gap_done, fin;
        int lo, hi;
        q_data.delete(); q_pres.delete(); q_idx.delete(); q_gap.delete(); q_hi.delete();
        n_trig = 0; n_done = 0;
        seen_hi = 0; prev_en = 0; gap_done = 0; fin = 0; lo = 0; hi = 0;
        b_loop = lp; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0; b_loop = 1'b0;
        for (int c = 0; c < max_cyc && !fin; c++) begin
            @(negedge clk);
            b_stop = 1'b0; b_wr = 1'b0; b_start = 1'b0;
            if (b_trig) begin
                n_trig++;
                q_pres.push_back(b_cdata);
                if (n_trig == stop_trig) b_stop = 1'b1;
                if (n_trig == wr_trig) begin
                    b_wr = 1'b1; b_addr = 2'd0; b_wdata = BAD;
                end
            end
            if (b_rv) begin
                q_idx.push_back(int'(b_ri));
                q_data.push_back(b_rd);
                if (gap_start && !gap_done) begin
                    b_start = 1'b1; gap_done = 1'b1;
                end
            end
            if (b_en) begin
                if (!prev_en && seen_hi) q_gap.push_back(lo);
                if (!prev_en) hi = 0;
                hi++;
                seen_hi = 1'b1;
            end else begin
                if (prev_en) begin q_hi.push_back(hi); lo = 0; end
                lo++;
            end
            prev_en = b_en;
            if (b_done) begin n_done++; fin = 1'b1; end
        end
        b_stop = 1'b0; b_wr = 1'b0; b_start = 1'b0;
        chk("run4_reached_done", fin, 1);
    endtask

    initial begin
        vec_rec_t tbl [4];
        logic [127:0] rdat;
        int ridx, rvn;
        bit fin;

        tbl[0] = '{vec: 128'ha6f2daeb_00000000_00000000_00000000, idx: 0,
                   exp: 128'h0cd901ab_bff6a5e8_caa9ba3e_bc1e2acc};
        tbl[1] = '{vec: 128'hd7b26248_00000000_00000000_00000000, idx: 1,
                   exp: 128'h7d99b908_bff6a5e8_caa9ba3e_bc1e2acc};
        tbl[2] = '{vec: 128'hf301a68a_00000000_00000000_00000000, idx: 2,
                   exp: 128'h592a7dca_bff6a5e8_caa9ba3e_bc1e2acc};
        tbl[3] = '{vec: 128'h0, idx: 3, exp: K};

        n_chk = 0; n_pass = 0; b_dead = 0;
        a_rst = 1; a_start = 0; a_loop = 0; a_stop = 0; a_wr = 0;
        a_key = '0; a_wdata = '0; a_addr = '0;
        b_rst = 1; b_start = 0; b_loop = 0; b_stop = 0; b_wr = 0;
        b_key = '0; b_wdata = '0; b_addr = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_busy", b_busy, 0);
        chk("rst_en", b_en, 0);
        chk("rst_trig", b_trig, 0);
        chk("rst_res_valid", b_rv, 0);
        chk("rst_done", b_done, 0);
        chk("rst_timeout", b_to, 0);
        chk("rst_core_data", b_cdata, 0);
        chk("rst_res_data", b_rd, 0);
        chk("rst1_busy", a_busy, 0);
        a_rst = 0; b_rst = 0;
        @(negedge clk);

        // single vector instance: latency and result
        a_key = K; a_wr = 1; a_addr = 0; a_wdata = V1_0;
        @(negedge clk);
        a_wr = 0; a_start = 1;
        @(negedge clk);
        a_start = 0;
        chk("u1_setup_en", a_en, 0);
        chk("u1_setup_trig", a_trig, 0);
        chk("u1_setup_busy", a_busy, 1);
        @(negedge clk);
        chk("u1_trig_t2", a_trig, 1);
        chk("u1_en_t2", a_en, 1);
        chk("u1_core_data", a_cdata, V1_0);
        chk("u1_core_key", a_ckey, K);
        rvn = 0; fin = 0; rdat = '0; ridx = -1;
        for (int c = 0; c < 200 && !fin; c++) begin
            @(negedge clk);
            if (a_rv) begin rvn++; rdat = a_rd; ridx = int'(a_ri); end
            if (a_done) fin = 1;
        end
        chk("u1_done_seen", fin, 1);
        chk("u1_res_count", rvn, 1);
        chk("u1_res_data", rdat, 128'haa2bdb06_bff6a5e8_caa9ba3e_bc1e2acc);
        chk("u1_res_idx", ridx, 0);
        chk("u1_timeout", a_to, 0);
        @(negedge clk);
        chk("u1_idle_after_done", a_busy, 0);

        // write and start in the same cycle: SETUP sees the new vector
        a_wr = 1; a_wdata = V1_1; a_start = 1;
        @(negedge clk);
        a_wr = 0; a_start = 0;
        @(negedge clk);
        chk("u1_coll_trig", a_trig, 1);
        chk("u1_coll_data", a_cdata, V1_1);
        rvn = 0; fin = 0;
        for (int c = 0; c < 200 && !fin; c++) begin
            @(negedge clk);
            if (a_rv) begin rvn++; rdat = a_rd; end
            if (a_done) fin = 1;
        end
        chk("u1_coll_res", rdat, 128'haa2bdb07_bff6a5e8_caa9ba3e_bc1e2acc);
        chk("u1_coll_count", rvn, 1);

        // four-vector sequence
        b_key = K;
        for (int i = 0; i < 4; i++) begin
            b_wr = 1; b_addr = 2'(i); b_wdata = tbl[i].vec;
            @(negedge clk);
        end
        b_wr = 0;
        run4(0, 0, 0, 0, 600);
        chk("seq_res_count", q_idx.size(), 4);
        for (int i = 0; i < 4 && i < q_idx.size(); i++) begin
            chk($sformatf("seq_idx%0d", i), q_idx[i], tbl[i].idx);
            chk($sformatf("seq_data%0d", i), q_data[i], tbl[i].exp);
        end
        // en is low across the GAP cycles plus the one SETUP cycle
        chk("seq_gap_count", q_gap.size(), 3);
        for (int i = 0; i < q_gap.size(); i++)
            chk($sformatf("seq_gap%0d", i), q_gap[i], GAP + 1);
        chk("seq_trig_count", n_trig, 4);
        chk("seq_done_count", n_done, 1);
        @(negedge clk);
        chk("seq_idle_after_done", b_busy, 0);
        chk("seq_no_timeout", b_to, 0);

        // busy write dropped, start in GAP ignored
        run4(0, 0, 2, 1, 600);
        chk("busy_res_count", q_idx.size(), 4);
        chk("busy_trig_count", n_trig, 4);
        @(negedge clk);

        // timeout: core never answers
        b_dead = 1;
        run4(0, 0, 0, 0, 1000);
        b_dead = 0;
        chk("to_res_count", q_idx.size(), 0);
        chk("to_run_count", q_hi.size(), 4);
        if (q_hi.size() > 0) chk("to_run_len0", q_hi[0], TO_CYC);
        if (q_hi.size() > 3) chk("to_run_len3", q_hi[3], TO_CYC);
        chk("to_done_count", n_done, 1);
        @(negedge clk);
        chk("to_sticky", b_to, 1);

        // loop with stop during vector 1 of second pass; start clears timeout
        run4(1, 6, 0, 0, 1000);
        chk("loop_res_count", q_idx.size(), 6);
        for (int i = 0; i < 6 && i < q_idx.size(); i++)
            chk($sformatf("loop_idx%0d", i), q_idx[i], i % 4);
        chk("loop_pres_count", q_pres.size(), 6);
        if (q_pres.size() > 5) chk("loop_last_pres", q_pres[5], tbl[1].vec);
        chk("loop_timeout_cleared", b_to, 0);
        @(negedge clk);

        // reset mid-RUN
        b_start = 1;
        @(negedge clk);
        b_start = 0;
        for (int c = 0; c < 20 && !b_en; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("mid_in_run", b_en, 1);
        b_rst = 1;
        @(negedge clk);
        b_rst = 0;
        chk("mid_rst_busy", b_busy, 0);
        chk("mid_rst_en", b_en, 0);
        chk("mid_rst_done", b_done, 0);
        chk("mid_rst_core_data", b_cdata, 0);
        chk("mid_rst_core_key", b_ckey, 0);
        chk("mid_rst_res_valid", b_rv, 0);
        @(negedge clk);
        chk("mid_rst_no_done", b_done, 0);
        run4(0, 0, 0, 0, 600);
        chk("mid_rerun_count", q_idx.size(), 4);
        if (q_idx.size() > 0) begin
            chk("mid_rerun_idx0", q_idx[0], 0);
            chk("mid_rerun_data0", q_data[0], tbl[0].exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
